// File: rtl/map_tile_store.sv
// -----------------------------------------------------------------------------
// map_tile_store
//   21 x 21 tile map for a maze game. Holds one 3-bit tile code per cell and
//   serves two independent zero-latency read ports: one for the display and
//   one for game-logic queries. After reset or a restart request, the default
//   maze is streamed into the array one cell per clock. Once the whole map is
//   loaded, a single req/ack write port lets game logic change tiles.
//   The block keeps a live count of orb tiles and raises event pulses when a
//   big orb is eaten and when the last orb disappears.
// -----------------------------------------------------------------------------
module map_tile_store (
  input  logic       clock_50,
  input  logic       reset,
  input  logic       restart,
  input  logic [4:0] map_x,
  input  logic [4:0] map_y,
  output logic [2:0] sprite_type,
  input  logic [4:0] q_x,
  input  logic [4:0] q_y,
  output logic [2:0] q_type,
  input  logic       wr_req,
  input  logic [4:0] wr_x,
  input  logic [4:0] wr_y,
  input  logic [2:0] wr_type,
  output logic       wr_ack,
  output logic       wr_err,
  output logic       ready,
  output logic [8:0] orbs_left,
  output logic       big_orb_eaten,
  output logic       level_clear
);

  // Map geometry and tile codes.
  localparam logic [4:0] LAST_COORD = 5'd20;
  localparam logic [8:0] ORB_MAX    = 9'd441;
  localparam logic [2:0] TILE_BLACK = 3'b000;
  localparam logic [2:0] TILE_BIG   = 3'b001;
  localparam logic [2:0] TILE_SMALL = 3'b010;
  localparam logic [2:0] TILE_BLUE  = 3'b011;

  typedef enum logic {
    ST_INIT,
    ST_READY
  } state_t;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------

  // True when (x, y) addresses a real cell of the map.
  function automatic logic coord_ok(input logic [4:0] x, input logic [4:0] y);
    return (x <= LAST_COORD) && (y <= LAST_COORD);
  endfunction

  // Raster index: row-major, x fastest.
  function automatic logic [8:0] cell_index(input logic [4:0] x, input logic [4:0] y);
    return ({4'd0, y} * 9'd21) + {4'd0, x};
  endfunction

  // Both orb flavours count toward orbs_left. Codes 101..111 are stored but
  // are not orbs.
  function automatic logic is_orb(input logic [2:0] t);
    return (t == TILE_BIG) || (t == TILE_SMALL);
  endfunction

  // Default maze layout.
  //   - The outer ring is wall.
  //   - The four big orbs sit just inside the corners.
  //   - Pillars stand on even/even coordinates.
  //   - Every other cell holds a small orb.
  function automatic logic [2:0] default_tile(input logic [4:0] x, input logic [4:0] y);
    logic [2:0] t;
    if ((x == 5'd0) || (x == LAST_COORD) || (y == 5'd0) || (y == LAST_COORD)) begin
      t = TILE_BLUE;
    end else if (((x == 5'd1) || (x == 5'd19)) && ((y == 5'd1) || (y == 5'd19))) begin
      t = TILE_BIG;
    end else if (!x[0] && !y[0]) begin
      t = TILE_BLUE;
    end else begin
      t = TILE_SMALL;
    end
    return t;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t     state;
  state_t     state_next;
  logic [4:0] scan_x;
  logic [4:0] scan_y;
  logic [2:0] tiles [0:440];

  // Decoded controls.
  logic       scan_last;
  logic       init_active;
  logic [8:0] init_idx;
  logic [2:0] init_tile;
  logic       wr_accept;
  logic       wr_in_range;
  logic [8:0] wr_idx;
  logic [2:0] wr_old;
  logic       old_orb;
  logic       new_orb;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------

  // State register.
  always_ff @(posedge clock_50 or negedge reset) begin
    if (!reset) begin
      state <= ST_INIT;
    end else begin
      // NOTE: clocked state always uses non-blocking assignment so every
      // register samples pre-edge values regardless of statement order.
      state <= state_next;
    end
  end

  // Next-state logic.
  // Restart wins in both states. INIT leaves on the edge that writes the
  // final cell.
  always_comb begin
    // NOTE: a default first keeps every path assigned, so no latch is inferred.
    state_next = state;
    case (state)
      ST_INIT:  if (!restart && scan_last) state_next = ST_READY;
      ST_READY: if (restart)               state_next = ST_INIT;
    endcase
  end

  // FSM outputs and cycle-level control decode.
  always_comb begin
    ready       = (state == ST_READY);
    scan_last   = (scan_x == LAST_COORD) && (scan_y == LAST_COORD);
    init_active = (state == ST_INIT) && !restart;
    init_idx    = cell_index(scan_x, scan_y);
    init_tile   = default_tile(scan_x, scan_y);
    // The wr_ack term spaces accepted writes at least two cycles apart for a
    // requester that keeps wr_req high through the acknowledge.
    wr_accept   = (state == ST_READY) && wr_req && !wr_ack && !restart;
  end

  // ---------------------------------------------------------------------------
  // Read ports
  // ---------------------------------------------------------------------------

  // Write-port lookup of the tile about to be replaced.
  always_comb begin
    wr_in_range = coord_ok(wr_x, wr_y);
    wr_idx      = cell_index(wr_x, wr_y);
    wr_old      = TILE_BLACK;
    if (wr_in_range) wr_old = tiles[wr_idx];
    old_orb     = is_orb(wr_old);
    new_orb     = is_orb(wr_type);
  end

  // Display read port.
  // Blanks out while loading or when addressed off-map.
  always_comb begin
    sprite_type = TILE_BLACK;
    if (ready && coord_ok(map_x, map_y)) sprite_type = tiles[cell_index(map_x, map_y)];
  end

  // Game-logic query port, same masking rules as the display port.
  always_comb begin
    q_type = TILE_BLACK;
    if (ready && coord_ok(q_x, q_y)) q_type = tiles[cell_index(q_x, q_y)];
  end

  // ---------------------------------------------------------------------------
  // Tile array
  // ---------------------------------------------------------------------------

  // Array write: the loader during INIT, or an accepted in-range write.
  // NOTE: the tile array is deliberately left out of reset. Its contents are
  // rebuilt by the loader, and a reset on 441 cells would only cost fabric.
  always_ff @(posedge clock_50) begin
    if (init_active) begin
      tiles[init_idx] <= init_tile;
    end else if (wr_accept && wr_in_range) begin
      tiles[wr_idx] <= wr_type;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------

  // Scan pointer, orb counter, acknowledge and event pulses.
  always_ff @(posedge clock_50 or negedge reset) begin
    if (!reset) begin
      scan_x        <= 5'd0;
      scan_y        <= 5'd0;
      orbs_left     <= 9'd0;
      wr_ack        <= 1'b0;
      wr_err        <= 1'b0;
      big_orb_eaten <= 1'b0;
      level_clear   <= 1'b0;
    end else begin
      // All response outputs are single-cycle unless re-armed below.
      wr_ack        <= 1'b0;
      wr_err        <= 1'b0;
      big_orb_eaten <= 1'b0;
      level_clear   <= 1'b0;

      if (restart) begin
        // Holding restart parks the loader on cell (0,0) without writing.
        scan_x    <= 5'd0;
        scan_y    <= 5'd0;
        orbs_left <= 9'd0;
      end else if (init_active) begin
        if (is_orb(init_tile) && (orbs_left != ORB_MAX)) begin
          orbs_left <= orbs_left + 9'd1;
        end
        // Raster advance. The wrap after (20,20) leaves the scan at (0,0),
        // ready for the next reload.
        if (scan_x == LAST_COORD) begin
          scan_x <= 5'd0;
          scan_y <= (scan_y == LAST_COORD) ? 5'd0 : scan_y + 5'd1;
        end else begin
          scan_x <= scan_x + 5'd1;
        end
      end else if (wr_accept) begin
        wr_ack <= 1'b1;
        wr_err <= !wr_in_range;
        if (wr_in_range) begin
          if (old_orb && !new_orb) begin
            if (orbs_left != 9'd0) orbs_left <= orbs_left - 9'd1;
            level_clear <= (orbs_left == 9'd1);
          end else if (!old_orb && new_orb) begin
            if (orbs_left != ORB_MAX) orbs_left <= orbs_left + 9'd1;
          end
          big_orb_eaten <= (wr_old == TILE_BIG) && !new_orb;
        end
      end
    end
  end

endmodule

// File: tb/tb_map_tile_store.sv
// -----------------------------------------------------------------------------
// tb_map_tile_store
//   Directed bench for map_tile_store. Expected values are hand-computed from
//   the default layout: 280 orbs in total, and 126 orbs among the first 200
//   raster cells.
// -----------------------------------------------------------------------------
module tb_map_tile_store;

  logic       clock_50 = 1'b0;
  logic       reset    = 1'b1;
  logic       restart  = 1'b0;
  logic [4:0] map_x    = 5'd0;
  logic [4:0] map_y    = 5'd0;
  logic [2:0] sprite_type;
  logic [4:0] q_x      = 5'd0;
  logic [4:0] q_y      = 5'd0;
  logic [2:0] q_type;
  logic       wr_req   = 1'b0;
  logic [4:0] wr_x     = 5'd0;
  logic [4:0] wr_y     = 5'd0;
  logic [2:0] wr_type  = 3'd0;
  logic       wr_ack;
  logic       wr_err;
  logic       ready;
  logic [8:0] orbs_left;
  logic       big_orb_eaten;
  logic       level_clear;

  map_tile_store dut (
    .clock_50      (clock_50),
    .reset         (reset),
    .restart       (restart),
    .map_x         (map_x),
    .map_y         (map_y),
    .sprite_type   (sprite_type),
    .q_x           (q_x),
    .q_y           (q_y),
    .q_type        (q_type),
    .wr_req        (wr_req),
    .wr_x          (wr_x),
    .wr_y          (wr_y),
    .wr_type       (wr_type),
    .wr_ack        (wr_ack),
    .wr_err        (wr_err),
    .ready         (ready),
    .orbs_left     (orbs_left),
    .big_orb_eaten (big_orb_eaten),
    .level_clear   (level_clear)
  );

  always #5 clock_50 = ~clock_50;

  int tests_run    = 0;
  int tests_failed = 0;

  // Count the high cycles of each pulse output, sampled on the falling edge.
  int ack_count = 0;
  int lc_count  = 0;
  int big_count = 0;
  always @(negedge clock_50) begin
    if (wr_ack        === 1'b1) ack_count <= ack_count + 1;
    if (level_clear   === 1'b1) lc_count  <= lc_count + 1;
    if (big_orb_eaten === 1'b1) big_count <= big_count + 1;
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock_50);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  // Drive both read ports to (x, y) and compare both against exp.
  task automatic read_check(input string tag, input logic [4:0] x, input logic [4:0] y,
                            input logic [2:0] exp);
    map_x = x; map_y = y;
    q_x   = x; q_y   = y;
    #1;
    check({tag, "_disp"}, sprite_type, exp);
    check({tag, "_q"}, q_type, exp);
  endtask

  // Called right after the edge on which the scan restarted at (0,0).
  task automatic load_check(input string tag, input int lc_before, input int ack_before);
    ticks(440);
    check({tag, "_not_ready_440"}, ready, 1'b0);
    tick();
    check({tag, "_ready_441"}, ready, 1'b1);
    check({tag, "_orbs_280"}, orbs_left, 9'd280);
    check({tag, "_no_lc_in_init"}, lc_count - lc_before, 0);
    check({tag, "_no_ack_in_init"}, ack_count - ack_before, 0);
  endtask

  // Full handshake. Returns the response flags sampled with the ack.
  task automatic do_write(input logic [4:0] x, input logic [4:0] y, input logic [2:0] t,
                          output logic err, output logic big, output logic lc);
    logic got;
    got = 1'b0;
    wr_x = x; wr_y = y; wr_type = t; wr_req = 1'b1;
    for (int i = 0; i < 10 && !got; i++) begin
      tick();
      if (wr_ack === 1'b1) got = 1'b1;
    end
    err = wr_err; big = big_orb_eaten; lc = level_clear;
    wr_req = 1'b0;
    if (!got) check("write_ack_timeout", got, 1'b1);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1);
  end

  initial begin
    logic e, b, l;
    int   lc0, big0, ack0;

    // Reset entry: force a clean negedge on reset.
    #1 reset = 1'b0;
    #1;
    check("rst_ready", ready, 1'b0);
    check("rst_orbs", orbs_left, 9'd0);
    check("rst_ack", wr_ack, 1'b0);
    check("rst_err", wr_err, 1'b0);
    check("rst_big", big_orb_eaten, 1'b0);
    check("rst_lc", level_clear, 1'b0);
    check("rst_sprite", sprite_type, 3'd0);
    ticks(2);
    reset = 1'b1;
    load_check("load1", lc_count, ack_count);

    // Default layout spot checks.
    read_check("rd_0_0", 5'd0, 5'd0, 3'b011);
    read_check("rd_1_1", 5'd1, 5'd1, 3'b001);
    read_check("rd_2_2", 5'd2, 5'd2, 3'b011);
    read_check("rd_3_1", 5'd3, 5'd1, 3'b010);
    read_check("rd_25_3", 5'd25, 5'd3, 3'b000);
    read_check("rd_19_19", 5'd19, 5'd19, 3'b001);
    read_check("rd_20_5", 5'd20, 5'd5, 3'b011);
    read_check("rd_3_21", 5'd3, 5'd21, 3'b000);

    // Held request: ack after one edge, then a gap, then a second ack.
    q_x = 5'd3; q_y = 5'd1;
    wr_x = 5'd3; wr_y = 5'd1; wr_type = 3'b000; wr_req = 1'b1;
    tick();
    check("w31_ack1", wr_ack, 1'b1);
    check("w31_err", wr_err, 1'b0);
    check("w31_orbs", orbs_left, 9'd279);
    check("w31_q", q_type, 3'b000);
    tick();
    check("w31_ack_gap", wr_ack, 1'b0);
    tick();
    check("w31_ack2", wr_ack, 1'b1);
    check("w31_orbs_same", orbs_left, 9'd279);
    wr_req = 1'b0;
    tick();
    check("w31_ack_low", wr_ack, 1'b0);

    // Eating and restoring a big orb.
    do_write(5'd1, 5'd1, 3'b000, e, b, l);
    check("big_eat_pulse", b, 1'b1);
    check("big_eat_orbs", orbs_left, 9'd278);
    do_write(5'd1, 5'd1, 3'b001, e, b, l);
    check("big_restore_pulse", b, 1'b0);
    check("big_restore_orbs", orbs_left, 9'd279);

    // Out of range: (21,4) must not alias into (0,5).
    do_write(5'd21, 5'd4, 3'b000, e, b, l);
    check("oor_err", e, 1'b1);
    check("oor_orbs", orbs_left, 9'd279);
    read_check("oor_alias_0_5", 5'd0, 5'd5, 3'b011);

    // Codes 101..111 are stored verbatim and are not orbs.
    do_write(5'd5, 5'd1, 3'b110, e, b, l);
    check("c110_orbs", orbs_left, 9'd278);
    read_check("c110_read", 5'd5, 5'd1, 3'b110);
    do_write(5'd5, 5'd1, 3'b101, e, b, l);
    check("c101_orbs", orbs_left, 9'd278);

    // Clear every remaining orb. The final write is (19,19), a big orb.
    lc0 = lc_count; big0 = big_count;
    for (int y = 1; y <= 19; y++) begin
      for (int x = 1; x <= 19; x++) begin
        if ((x % 2 == 1) || (y % 2 == 1)) do_write(5'(x), 5'(y), 3'b000, e, b, l);
      end
    end
    check("clear_last_lc", l, 1'b1);
    check("clear_last_big", b, 1'b1);
    check("clear_orbs_zero", orbs_left, 9'd0);
    check("clear_lc_once", lc_count - lc0, 1);
    check("clear_big_four", big_count - big0, 4);

    // One-cycle restart, then a full reload.
    restart = 1'b1;
    tick();
    restart = 1'b0;
    check("rs_ready_low", ready, 1'b0);
    check("rs_orbs_zero", orbs_left, 9'd0);
    read_check("rs_masked", 5'd0, 5'd0, 3'b000);
    load_check("load2", lc_count, ack_count);
    read_check("rs_reloaded_3_1", 5'd3, 5'd1, 3'b010);

    // Restart with a simultaneous request, held for 3 edges. The request stays
    // pending through INIT and is taken on the first READY edge.
    ack0 = ack_count;
    wr_x = 5'd3; wr_y = 5'd1; wr_type = 3'b000; wr_req = 1'b1; restart = 1'b1;
    tick();
    check("rsw_no_ack", wr_ack, 1'b0);
    check("rsw_ready_low", ready, 1'b0);
    ticks(2);
    restart = 1'b0;
    load_check("load3", lc_count, ack0);
    tick();
    check("pend_ack", wr_ack, 1'b1);
    check("pend_orbs", orbs_left, 9'd279);
    wr_req = 1'b0;
    tick();

    // Reset during INIT, with the loader on cell 200.
    restart = 1'b1;
    tick();
    restart = 1'b0;
    ticks(200);
    check("mid_init_orbs_126", orbs_left, 9'd126);
    reset = 1'b0;
    #1;
    check("mid_init_rst_orbs", orbs_left, 9'd0);
    check("mid_init_rst_ready", ready, 1'b0);
    ticks(2);
    reset = 1'b1;
    load_check("load4", lc_count, ack_count);

    // Reset while an acknowledge is high, with the request still held.
    wr_x = 5'd5; wr_y = 5'd1; wr_type = 3'b000; wr_req = 1'b1;
    tick();
    check("wrst_ack_before", wr_ack, 1'b1);
    reset = 1'b0;
    #1;
    check("wrst_ack_dropped", wr_ack, 1'b0);
    check("wrst_orbs", orbs_left, 9'd0);
    check("wrst_ready", ready, 1'b0);
    ack0 = ack_count;
    ticks(2);
    reset = 1'b1;
    load_check("load5", lc_count, ack0);
    tick();
    check("wrst_pend_ack", wr_ack, 1'b1);
    check("wrst_pend_orbs", orbs_left, 9'd279);
    wr_req = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
